// File: rtl/approx_mul_pkg.sv
// rtl/approx_mul_pkg.sv - shared widths, sweep size and state encoding for the approximate-multiplier BIST
package approx_mul_pkg;

  localparam int W_DEF       = 6;
  localparam int N_PAIRS_DEF = 1 << (2 * W_DEF);
  localparam int CNT_W_DEF   = 2 * W_DEF + 1;
  localparam int MAX_W_DEF   = 2 * W_DEF;
  localparam int SUM_W       = 25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/err_accum.sv
// rtl/err_accum.sv - error computation and count/sum/max accumulators with clear and enable
module err_accum
  import approx_mul_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic [W-1:0]            a,
  input  logic [W-1:0]            b,
  input  logic [2*W-1:0]          prod,
  output logic [2*W:0]            err_count,
  output logic signed [SUM_W-1:0] err_sum,
  output logic [2*W-1:0]          max_abs_err
);

  logic [2*W-1:0]          exact;
  logic signed [2*W:0]     err;
  logic [2*W:0]            err_mag;
  logic [2*W:0]            count_q, count_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic [2*W-1:0]          max_q, max_d;

  assign exact   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign err     = $signed({1'b0, prod}) - $signed({1'b0, exact});
  assign err_mag = err[2*W] ? (~err + 1'b1) : err;

  always_comb begin
    count_d = count_q;
    sum_d   = sum_q;
    max_d   = max_q;
    if (clr) begin
      count_d = '0;
      sum_d   = '0;
      max_d   = '0;
    end else if (en) begin
      if (err != '0) count_d = count_q + 1'b1;
      sum_d = sum_q + {{(SUM_W-2*W-1){err[2*W]}}, err};
      if (err_mag > {1'b0, max_q}) max_d = err_mag[2*W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      sum_q   <= '0;
      max_q   <= '0;
    end else begin
      count_q <= count_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
    end
  end

  assign err_count   = count_q;
  assign err_sum     = sum_q;
  assign max_abs_err = max_q;

endmodule

// File: rtl/approx_mul_bist.sv
// rtl/approx_mul_bist.sv - exhaustive operand sweep of an external multiplier with error statistics
module approx_mul_bist
  import approx_mul_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int N_PAIRS = N_PAIRS_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic [W-1:0]                  a_out,
  output logic [W-1:0]                  b_out,
  input  logic [2*W-1:0]                prod_in,
  output logic                          busy,
  output logic                          done,
  output logic [2*W:0]                  err_count,
  output logic signed [SUM_W-1:0]       err_sum,
  output logic [2*W-1:0]                max_abs_err,
  output logic signed [SUM_W-2*W-1:0]   mean_err
);

  localparam logic [2*W-1:0] LAST_IDX = (2*W)'(N_PAIRS - 1);

  state_e         state_q, state_d;
  logic [2*W-1:0] idx_q, idx_d;
  logic           clr;
  logic           cap;

  // Stage 1 holds the pair and its product so accumulation runs one edge later.
  logic           v1_q;
  logic [W-1:0]   a1_q, b1_q;
  logic [2*W-1:0] p1_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr     = 1'b0;
    cap     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          idx_d   = '0;
          clr     = 1'b1;
        end
      end
      ST_RUN: begin
        cap = 1'b1;
        if (idx_q == LAST_IDX) state_d = ST_DRAIN;
        else                   idx_d   = idx_q + 1'b1;
      end
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      v1_q    <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      p1_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      v1_q    <= cap;
      if (cap) begin
        a1_q <= a_out;
        b1_q <= b_out;
        p1_q <= prod_in;
      end
    end
  end

  err_accum #(.W(W)) u_err_accum (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .en          (v1_q),
    .a           (a1_q),
    .b           (b1_q),
    .prod        (p1_q),
    .err_count   (err_count),
    .err_sum     (err_sum),
    .max_abs_err (max_abs_err)
  );

  assign a_out    = idx_q[2*W-1:W];
  assign b_out    = idx_q[W-1:0];
  assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);
  assign mean_err = err_sum[SUM_W-1:2*W];

endmodule

// File: tb/tb_approx_mul_bist.sv
// tb/tb_approx_mul_bist.sv - scoreboard bench for approx_mul_bist with stub multipliers
module tb_approx_mul_bist;

  localparam int W  = 6;
  localparam int NP = 4096;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [W-1:0]       a_out, b_out;
  logic [2*W-1:0]     prod_in;
  logic               busy, done;
  logic [2*W:0]       err_count;
  logic signed [24:0] err_sum;
  logic [2*W-1:0]     max_abs_err;
  logic signed [12:0] mean_err;

  logic [2*W-1:0]     ab;
  int                 mode;
  int                 n_checks = 0;
  int                 n_fail   = 0;

  typedef struct {
    int cnt;
    int sum;
    int maxe;
    int mean;
  } res_t;

  res_t res_q[$];
  int   pair_q[$];
  res_t last_exp;

  approx_mul_bist #(.W(W), .N_PAIRS(NP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a_out       (a_out),
    .b_out       (b_out),
    .prod_in     (prod_in),
    .busy        (busy),
    .done        (done),
    .err_count   (err_count),
    .err_sum     (err_sum),
    .max_abs_err (max_abs_err),
    .mean_err    (mean_err)
  );

  always #5 clk = ~clk;

  assign ab = {6'b0, a_out} * {6'b0, b_out};

  // Stub multipliers: 0 exact, 1 off by one, 2 stuck at zero.
  always_comb begin
    case (mode)
      0:       prod_in = ab;
      1:       prod_in = ab + 12'd1;
      default: prod_in = '0;
    endcase
  end

  function automatic res_t model(input int m);
    res_t r;
    int p, e, ae;
    r = '{0, 0, 0, 0};
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        p = (m == 0) ? a * b : (m == 1) ? a * b + 1 : 0;
        e = p - a * b;
        ae = (e < 0) ? -e : e;
        if (e != 0) r.cnt++;
        r.sum += e;
        if (ae > r.maxe) r.maxe = ae;
      end
    end
    r.mean = r.sum >>> 12;
    return r;
  endfunction

  task automatic run_sweep(input int m, input bit trace, input int restart_at);
    res_t exp;
    int   n;
    int   pr;
    mode = m;
    res_q.push_back(model(m));
    if (trace) begin
      for (int a = 0; a < 64; a++)
        for (int b = 0; b < 64; b++)
          pair_q.push_back((a << 6) | b);
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_flags: busy=%0b done=%0b required busy=1 done=0", busy, done);
    end
    n_checks++;
    if (err_count !== '0 || err_sum !== '0 || max_abs_err !== '0) begin
      n_fail++;
      $display("FAIL start_clear: cnt=%0d sum=%0d max=%0d required all 0", err_count, err_sum, max_abs_err);
    end
    while (!done && n < 5000) begin
      if (trace && n < NP && pair_q.size() > 0) begin
        pr = pair_q.pop_front();
        n_checks++;
        if ({a_out, b_out} !== 12'(pr)) begin
          n_fail++;
          $display("FAIL trace_pair%0d: a=%0d b=%0d required a=%0d b=%0d", n, a_out, b_out, pr >> 6, pr & 63);
        end
      end
      if (restart_at >= 0 && n == restart_at + 1) begin
        n_checks++;
        if ({a_out, b_out} !== 12'(n) || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL restart_ignored: a=%0d b=%0d busy=%0b required a=%0d b=%0d busy=1", a_out, b_out, busy, n >> 6, n & 63);
        end
      end
      start = (n == restart_at) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    n_checks++;
    if (n !== 4097) begin
      n_fail++;
      $display("FAIL done_edge: done seen after edge %0d required 4097", n);
    end
    if (trace) begin
      n_checks++;
      if (a_out !== 6'd63 || b_out !== 6'd63 || pair_q.size() != 0) begin
        n_fail++;
        $display("FAIL trace_hold: a=%0d b=%0d left=%0d required a=63 b=63 left=0", a_out, b_out, pair_q.size());
      end
    end
    exp = res_q.pop_front();
    last_exp = exp;
    n_checks++;
    if (int'(err_count) !== exp.cnt) begin
      n_fail++;
      $display("FAIL err_count_m%0d: got %0d required %0d", m, err_count, exp.cnt);
    end
    n_checks++;
    if (int'(err_sum) !== exp.sum) begin
      n_fail++;
      $display("FAIL err_sum_m%0d: got %0d required %0d", m, err_sum, exp.sum);
    end
    n_checks++;
    if (int'(max_abs_err) !== exp.maxe) begin
      n_fail++;
      $display("FAIL max_abs_err_m%0d: got %0d required %0d", m, max_abs_err, exp.maxe);
    end
    n_checks++;
    if (int'(mean_err) !== exp.mean) begin
      n_fail++;
      $display("FAIL mean_err_m%0d: got %0d required %0d", m, mean_err, exp.mean);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_at_done_m%0d: got %0b required 0", m, busy);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (a_out !== '0 || b_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: a=%0d b=%0d busy=%0b done=%0b required all 0", a_out, b_out, busy, done);
    end
    n_checks++;
    if (err_count !== '0 || err_sum !== '0 || max_abs_err !== '0 || mean_err !== '0) begin
      n_fail++;
      $display("FAIL reset_results: cnt=%0d sum=%0d max=%0d mean=%0d required all 0", err_count, err_sum, max_abs_err, mean_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_wait: busy=%0b done=%0b required 0 0", busy, done);
    end
  endtask

  task automatic test_done_hold;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b1 || int'(err_count) !== last_exp.cnt || int'(err_sum) !== last_exp.sum ||
        int'(max_abs_err) !== last_exp.maxe) begin
      n_fail++;
      $display("FAIL done_hold: done=%0b cnt=%0d sum=%0d max=%0d required 1 %0d %0d %0d",
               done, err_count, err_sum, max_abs_err, last_exp.cnt, last_exp.sum, last_exp.maxe);
    end
  endtask

  task automatic test_reset_mid_run;
    int n;
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (a_out !== '0 || b_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_ctrl: a=%0d b=%0d busy=%0b done=%0b required all 0", a_out, b_out, busy, done);
    end
    n_checks++;
    if (err_count !== '0 || err_sum !== '0 || max_abs_err !== '0 || mean_err !== '0) begin
      n_fail++;
      $display("FAIL abort_results: cnt=%0d sum=%0d max=%0d mean=%0d required all 0", err_count, err_sum, max_abs_err, mean_err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err_count !== '0) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%0b done=%0b cnt=%0d required 0 0 0", busy, done, err_count);
    end
    run_sweep(2, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    run_sweep(0, 1'b1, -1);
    test_done_hold();
    run_sweep(1, 1'b0, -1);
    run_sweep(2, 1'b0, -1);
    run_sweep(1, 1'b0, 100);
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/approx_mul_bist.md
APPROX_MUL_BIST -- requirements
Module: approx_mul_bist

Interface
REQ-001 SHALL have parameter W, default 6, meaning the operand width of the multiplier under test.
REQ-002 SHALL have parameter N_PAIRS, default 4096 (2^(2W)), meaning the number of operand pairs swept.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port start, input, 1, a request to begin a sweep; sampled only in IDLE or DONE.
REQ-006 SHALL have port a_out, output, W, the registered operand A driven to the multiplier's a input.
REQ-007 SHALL have port b_out, output, W, the registered operand B driven to the multiplier's b input.
REQ-008 SHALL have port prod_in, input, 2W, the multiplier's combinational prod output.
REQ-009 SHALL have port busy, output, 1, high while a sweep is in progress.
REQ-010 SHALL have port done, output, 1, a level held high from sweep completion until the next accepted start.
REQ-011 SHALL have port err_count, output, 2W+1, the number of pairs with prod_in != a*b.
REQ-012 SHALL have port err_sum, output, 25, the signed sum of (prod_in - a*b) over all pairs.
REQ-013 SHALL have port max_abs_err, output, 2W, the largest |prod_in - a*b| observed.
REQ-014 SHALL have port mean_err, output, 13, signed, equal to err_sum >>> 2W (arithmetic shift, floor).

Function
REQ-015 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-016 SHALL move IDLE/DONE -> RUN on edge E0 with start=1, clearing all accumulators and setting a_out=0, b_out=0, busy=1, done=0.
REQ-017 SHALL use a 2W-bit sweep index idx with a_out=idx[2W-1:W] and b_out=idx[W-1:0], so A is the outer loop and B the inner loop.
REQ-018 SHALL present pair k (k=0..N_PAIRS-1) after edge E_k.
REQ-019 SHALL capture prod_in together with a delayed copy of the operands at E_{k+1}, and accumulate at E_{k+2}.
REQ-020 SHALL compute the exact product a*b internally at 2W bits unsigned, and the error as a signed value 2W+1 bits wide.
REQ-021 SHALL add 1 to err_count only when the error is nonzero; err_sum SHALL add the signed error; max_abs_err SHALL update when |err| > the current maximum.
REQ-022 SHALL stop the index at N_PAIRS-1 with no wrap, and go RUN -> DRAIN after presenting the last pair.
REQ-023 SHALL go DRAIN -> DONE on E_4097 (the last accumulation), with busy=0, done=1 and final results visible after that edge.
REQ-024 SHALL ignore start while busy=1.
REQ-025 SHALL hold a_out and b_out at their last values in DRAIN/DONE.
REQ-026 SHALL hold results stable in DONE until a new start is accepted.
REQ-027 SHALL not saturate accumulators; widths are sized for the worst case (4096*3969 < 2^24).

Reset
REQ-028 SHALL, while rst_n=0, set state IDLE, idx=0, a_out=0, b_out=0, busy=0, done=0, err_count=0, err_sum=0, max_abs_err=0 and clear the pipeline registers.
REQ-029 SHALL abort a sweep on reset mid-RUN with no partial-result retention; after release the block SHALL wait in IDLE for start.

Structure
REQ-030 SHALL place W, N_PAIRS, the accumulator widths and the state encoding in shared package approx_mul_pkg.
REQ-031 SHALL have one sub-module, err_accum, holding the error computation, err_count, err_sum and max_abs_err registers, with a clear/enable interface.
REQ-032 SHALL treat the multiplier under test as external; the block SHALL not instantiate it.

Verification
REQ-033 SHALL cover: exact multiplier (prod=a*b) connected, start pulse -> done after E_4097, err_count=0, err_sum=0, max_abs_err=0, mean_err=0.
REQ-034 SHALL cover: stub prod=a*b+1 -> err_count=4096, err_sum=4096, max_abs_err=1, mean_err=1.
REQ-035 SHALL cover: stub prod=0 -> err_count=3969, err_sum=-4064256, max_abs_err=3969, mean_err=-993.
REQ-036 SHALL cover: an operand trace where the first three presented pairs are (0,0),(0,1),(0,2), pair 64 is (1,0), and the last is (63,63) with no wrap to (0,0).
REQ-037 SHALL cover: start re-pulsed mid-RUN -> ignored, with results identical to REQ-034.
REQ-038 SHALL cover: rst_n low at E_2000 -> all outputs 0 in IDLE; a new start then gives a full correct sweep.
